// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-fetch responder with a direct-mapped line store
// Hits answer one cycle after acceptance; misses fetch a 256-bit line from the burst port.
module imem_responder #(
   parameter int LINES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  imem_addr,
   input  logic [3:0]   imem_rmask,
   output logic [31:0]  imem_rdata,
   output logic         imem_resp,
   input  logic         flush,
   output logic [31:0]  bmem_addr,
   output logic         bmem_read,
   input  logic [255:0] bmem_rdata,
   input  logic         bmem_resp
);
   localparam int IW = $clog2(LINES);
   localparam int TW = 27 - IW;

   typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

   state_t             state, state_next;
   logic [31:0]        req_addr, req_addr_next;
   logic [LINES-1:0]   valid, valid_next;
   logic [TW-1:0]      tags  [LINES];
   logic [255:0]       lines [LINES];
   logic [31:0]        rdata_next, baddr_next;
   logic               resp_next, bread_next, fill;
   logic [IW-1:0]      lookup_idx, fill_idx;
   logic [TW-1:0]      lookup_tag;
   logic [255:0]       lookup_line;
   logic               hit;
   logic               unused_bits;

   assign lookup_idx  = imem_addr[5 +: IW];
   assign lookup_tag  = imem_addr[31 -: TW];
   assign lookup_line = lines[lookup_idx];
   assign hit         = valid[lookup_idx] && (tags[lookup_idx] == lookup_tag);
   assign fill_idx    = req_addr[5 +: IW];
   assign unused_bits = ^{imem_addr[1:0], req_addr[1:0]};

   always_comb begin
      state_next    = state;
      req_addr_next = req_addr;
      resp_next     = 1'b0;
      rdata_next    = imem_rdata;
      bread_next    = bmem_read;
      baddr_next    = bmem_addr;
      fill          = 1'b0;
      // Lookups above use the pre-flush valid bits; the clear lands at this edge.
      valid_next    = flush ? '0 : valid;
      case (state)
         IDLE: begin
            if (imem_rmask != 4'h0) begin
               req_addr_next = imem_addr;
               if (hit) begin
                  rdata_next = lookup_line[{imem_addr[4:2], 5'b0} +: 32];
                  resp_next  = 1'b1;
                  state_next = RESP;
               end else begin
                  bread_next = 1'b1;
                  baddr_next = {imem_addr[31:5], 5'b0};
                  state_next = MISS;
               end
            end
         end
         MISS: begin
            if (bmem_resp) begin
               fill       = 1'b1;
               if (!flush) valid_next[fill_idx] = 1'b1;
               rdata_next = bmem_rdata[{req_addr[4:2], 5'b0} +: 32];
               resp_next  = 1'b1;
               bread_next = 1'b0;
               state_next = RESP;
            end
         end
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         req_addr   <= '0;
         valid      <= '0;
         imem_resp  <= 1'b0;
         imem_rdata <= '0;
         bmem_read  <= 1'b0;
         bmem_addr  <= '0;
      end else begin
         state      <= state_next;
         req_addr   <= req_addr_next;
         valid      <= valid_next;
         imem_resp  <= resp_next;
         imem_rdata <= rdata_next;
         bmem_read  <= bread_next;
         bmem_addr  <= baddr_next;
      end
   end

   // Data and tag arrays carry no reset; valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (rst && fill) begin
         lines[fill_idx] <= bmem_rdata;
         tags[fill_idx]  <= req_addr[31 -: TW];
      end
   end
endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed self-checking bench for imem_responder
module tb_imem_responder;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [31:0]  imem_addr = '0;
   logic [3:0]   imem_rmask = '0;
   logic [31:0]  imem_rdata;
   logic         imem_resp;
   logic         flush = 1'b0;
   logic [31:0]  bmem_addr;
   logic         bmem_read;
   logic [255:0] bmem_rdata = '0;
   logic         bmem_resp = 1'b0;

   int tests = 0;
   int fails = 0;

   imem_responder #(.LINES(4)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
      .imem_rdata(imem_rdata), .imem_resp(imem_resp), .flush(flush),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_rdata(bmem_rdata),
      .bmem_resp(bmem_resp)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] make_line(input logic [31:0] base);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
      return l;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a);
      imem_addr  = a;
      imem_rmask = 4'hF;
      tick();
      imem_rmask = 4'h0;
   endtask

   task automatic fill_line(input logic [31:0] base);
      bmem_rdata = make_line(base);
      bmem_resp  = 1'b1;
      tick();
      bmem_resp  = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tests++; if (imem_resp !== 1'b0) begin fails++; $display("FAIL reset_resp got %b exp 0", imem_resp); end
      tests++; if (imem_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", imem_rdata); end
      tests++; if (bmem_read !== 1'b0) begin fails++; $display("FAIL reset_bread got %b exp 0", bmem_read); end
      tests++; if (bmem_addr !== 32'h0) begin fails++; $display("FAIL reset_baddr got %h exp 0", bmem_addr); end
   endtask

   task automatic test_cold_miss;
      issue(32'h1000_0004);
      for (int c = 0; c < 3; c++) begin
         tests++; if (bmem_read !== 1'b1) begin fails++; $display("FAIL cold_bread c%0d got %b exp 1", c, bmem_read); end
         tests++; if (bmem_addr !== 32'h1000_0000) begin fails++; $display("FAIL cold_baddr c%0d got %h exp 10000000", c, bmem_addr); end
         tests++; if (imem_resp !== 1'b0) begin fails++; $display("FAIL cold_early_resp c%0d got %b exp 0", c, imem_resp); end
         if (c < 2) tick();
      end
      fill_line(32'hA000_0000);
      tests++; if (imem_resp !== 1'b1) begin fails++; $display("FAIL cold_resp got %b exp 1", imem_resp); end
      tests++; if (imem_rdata !== 32'hA000_0001) begin fails++; $display("FAIL cold_rdata got %h exp a0000001", imem_rdata); end
      tests++; if (bmem_read !== 1'b0) begin fails++; $display("FAIL cold_bread_drop got %b exp 0", bmem_read); end
      tick();
      tests++; if (imem_resp !== 1'b0) begin fails++; $display("FAIL cold_resp_pulse got %b exp 0", imem_resp); end
   endtask

   task automatic test_hit;
      issue(32'h1000_001C);
      tests++; if (imem_resp !== 1'b1) begin fails++; $display("FAIL hit_resp got %b exp 1", imem_resp); end
      tests++; if (imem_rdata !== 32'hA000_0007) begin fails++; $display("FAIL hit_rdata got %h exp a0000007", imem_rdata); end
      tests++; if (bmem_read !== 1'b0) begin fails++; $display("FAIL hit_bread got %b exp 0", bmem_read); end
      tick();
      tests++; if (imem_resp !== 1'b0) begin fails++; $display("FAIL hit_resp_pulse got %b exp 0", imem_resp); end
   endtask

   task automatic test_back_to_back;
      issue(32'h1000_0008);
      tests++; if (imem_resp !== 1'b1) begin fails++; $display("FAIL b2b_resp got %b exp 1", imem_resp); end
      tests++; if (imem_rdata !== 32'hA000_0002) begin fails++; $display("FAIL b2b_rdata got %h exp a0000002", imem_rdata); end
      tick();
   endtask

   task automatic test_flush;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      issue(32'h1000_0004);
      tests++; if (bmem_read !== 1'b1) begin fails++; $display("FAIL flush_miss got %b exp 1", bmem_read); end
      bmem_rdata = make_line(32'hA000_0000);
      bmem_resp  = 1'b1;
      flush      = 1'b1;
      tick();
      bmem_resp  = 1'b0;
      flush      = 1'b0;
      tests++; if (imem_resp !== 1'b1) begin fails++; $display("FAIL flush_fill_resp got %b exp 1", imem_resp); end
      tests++; if (imem_rdata !== 32'hA000_0001) begin fails++; $display("FAIL flush_fill_rdata got %h exp a0000001", imem_rdata); end
      tick();
      issue(32'h1000_0004);
      tests++; if (bmem_read !== 1'b1) begin fails++; $display("FAIL flush_fill_not_valid got %b exp 1", bmem_read); end
      fill_line(32'hA000_0000);
      tests++; if (imem_resp !== 1'b1) begin fails++; $display("FAIL refill_resp got %b exp 1", imem_resp); end
      tick();
      imem_addr  = 32'h1000_0004;
      imem_rmask = 4'hF;
      flush      = 1'b1;
      tick();
      imem_rmask = 4'h0;
      flush      = 1'b0;
      tests++; if (imem_resp !== 1'b1) begin fails++; $display("FAIL flush_preflush_hit got %b exp 1", imem_resp); end
      tests++; if (imem_rdata !== 32'hA000_0001) begin fails++; $display("FAIL flush_preflush_rdata got %h exp a0000001", imem_rdata); end
      tick();
      issue(32'h1000_0004);
      tests++; if (bmem_read !== 1'b1) begin fails++; $display("FAIL flush_postflush_miss got %b exp 1", bmem_read); end
      fill_line(32'hA000_0000);
      tick();
   endtask

   task automatic test_conflict;
      issue(32'h1000_0080);
      tests++; if (bmem_read !== 1'b1) begin fails++; $display("FAIL conf_miss1 got %b exp 1", bmem_read); end
      tests++; if (bmem_addr !== 32'h1000_0080) begin fails++; $display("FAIL conf_baddr1 got %h exp 10000080", bmem_addr); end
      fill_line(32'hC000_0000);
      tests++; if (imem_rdata !== 32'hC000_0000) begin fails++; $display("FAIL conf_rdata1 got %h exp c0000000", imem_rdata); end
      tick();
      issue(32'h1000_0000);
      tests++; if (bmem_read !== 1'b1) begin fails++; $display("FAIL conf_evicted got %b exp 1", bmem_read); end
      tests++; if (bmem_addr !== 32'h1000_0000) begin fails++; $display("FAIL conf_baddr2 got %h exp 10000000", bmem_addr); end
      fill_line(32'hA000_0000);
      tests++; if (imem_rdata !== 32'hA000_0000) begin fails++; $display("FAIL conf_rdata2 got %h exp a0000000", imem_rdata); end
      tick();
      issue(32'h1000_0084);
      tests++; if (bmem_read !== 1'b1) begin fails++; $display("FAIL conf_evicted2 got %b exp 1", bmem_read); end
      fill_line(32'hC000_0000);
      tests++; if (imem_rdata !== 32'hC000_0001) begin fails++; $display("FAIL conf_rdata3 got %h exp c0000001", imem_rdata); end
      tick();
   endtask

   task automatic test_ignored_requests;
      int   rises = 0;
      int   early_resps = 0;
      logic prev = bmem_read;
      imem_addr  = 32'h3000_0000;
      imem_rmask = 4'hF;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bmem_read && !prev) rises++;
         prev = bmem_read;
         if (imem_resp) early_resps++;
      end
      fill_line(32'hD000_0000);
      tests++; if (imem_resp !== 1'b1) begin fails++; $display("FAIL ign_resp got %b exp 1", imem_resp); end
      tests++; if (imem_rdata !== 32'hD000_0000) begin fails++; $display("FAIL ign_rdata got %h exp d0000000", imem_rdata); end
      tests++; if (rises !== 1) begin fails++; $display("FAIL ign_read_txns got %0d exp 1", rises); end
      tests++; if (early_resps !== 0) begin fails++; $display("FAIL ign_early_resps got %0d exp 0", early_resps); end
      tick();
      tests++; if (imem_resp !== 1'b0) begin fails++; $display("FAIL ign_resp_during_resp got %b exp 0", imem_resp); end
      tests++; if (bmem_read !== 1'b0) begin fails++; $display("FAIL ign_bread_after got %b exp 0", bmem_read); end
      tick();
      imem_rmask = 4'h0;
      tests++; if (imem_resp !== 1'b1) begin fails++; $display("FAIL ign_next_accept got %b exp 1", imem_resp); end
      tick();
      tests++; if (imem_resp !== 1'b0) begin fails++; $display("FAIL ign_quiet got %b exp 0", imem_resp); end
   endtask

   task automatic test_reset_mid_miss;
      issue(32'h2000_0000);
      tests++; if (bmem_read !== 1'b1) begin fails++; $display("FAIL rmm_miss got %b exp 1", bmem_read); end
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tests++; if (bmem_read !== 1'b0) begin fails++; $display("FAIL rmm_bread got %b exp 0", bmem_read); end
      tests++; if (bmem_addr !== 32'h0) begin fails++; $display("FAIL rmm_baddr got %h exp 0", bmem_addr); end
      tests++; if (imem_resp !== 1'b0) begin fails++; $display("FAIL rmm_resp got %b exp 0", imem_resp); end
      tests++; if (imem_rdata !== 32'h0) begin fails++; $display("FAIL rmm_rdata got %h exp 0", imem_rdata); end
      fill_line(32'hE000_0000);
      tests++; if (imem_resp !== 1'b0) begin fails++; $display("FAIL rmm_stale_resp got %b exp 0", imem_resp); end
      tests++; if (bmem_read !== 1'b0) begin fails++; $display("FAIL rmm_stale_bread got %b exp 0", bmem_read); end
      tick();
      tests++; if (imem_resp !== 1'b0) begin fails++; $display("FAIL rmm_stale_resp2 got %b exp 0", imem_resp); end
      issue(32'h3000_0000);
      tests++; if (bmem_read !== 1'b1) begin fails++; $display("FAIL rmm_valid_cleared got %b exp 1", bmem_read); end
      fill_line(32'hD000_0000);
      tests++; if (imem_rdata !== 32'hD000_0000) begin fails++; $display("FAIL rmm_refill_rdata got %h exp d0000000", imem_rdata); end
      tick();
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit();
      test_back_to_back();
      test_flush();
      test_conflict();
      test_ignored_requests();
      test_reset_mid_miss();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
